// File: rtl/l2_arbiter_if.sv
// Wishbone line-transfer bundle shared by the L1 miss ports, the arbiter and the L2 CPU port.
// The master drives the request fields; the slave returns read data and the ACK/RTY terminations.
interface l2_arbiter_if;
    logic [11:0]  ADR;
    logic [127:0] DAT_M;
    logic [127:0] DAT_S;
    logic [15:0]  SEL;
    logic         WE;
    logic         CYC;
    logic         STB;
    logic         ACK;
    logic         RTY;

    modport master (
        output ADR, DAT_M, SEL, WE, CYC, STB,
        input  DAT_S, ACK, RTY
    );

    modport slave (
        input  ADR, DAT_M, SEL, WE, CYC, STB,
        output DAT_S, ACK, RTY
    );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the L2 CPU port between the L1 I-cache and D-cache miss ports.
// Latency: one arbitration cycle before the L2 sees the request; ACK/RTY/DAT_S pass through combinationally.
// Backpressure: the losing port simply waits with ACK=RTY=0; a silent L2 is cut off by the watchdog with RTY.
module l2_arbiter #(
    parameter int TIMEOUT_CYCLES   = 255,
    parameter bit FIRST_PRIORITY_D = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    l2_arbiter_if.slave  icache_wb,
    l2_arbiter_if.slave  dcache_wb,
    l2_arbiter_if.master l2_wb,
    output logic [1:0]   grant,
    output logic         timeout_err
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    localparam bit         WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] WD_LAST = WD_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

    state_t     state;
    logic       last_d;   // 1 when the D port owned the most recently terminated cycle
    logic [7:0] wd_cnt;

    logic req_i;
    logic req_d;
    logic own_i;
    logic own_d;
    logic busy;
    logic own_cyc;
    logic own_stb;
    logic abort;
    logic wd_hit;
    logic fire;
    logic done_ack;
    logic done_rty;

    assign req_i = icache_wb.CYC & icache_wb.STB;
    assign req_d = dcache_wb.CYC & dcache_wb.STB;

    assign own_i   = (state == GRANT_I);
    assign own_d   = (state == GRANT_D);
    assign busy    = own_i | own_d;
    assign own_cyc = own_d ? dcache_wb.CYC : icache_wb.CYC;
    assign own_stb = own_d ? dcache_wb.STB : icache_wb.STB;

    // A master dropping CYC wins over any termination the L2 might present in the same cycle.
    assign abort    = busy & ~own_cyc;
    assign wd_hit   = WD_EN & busy & (wd_cnt == WD_LAST);
    assign done_ack = busy & ~abort & l2_wb.ACK;
    assign fire     = wd_hit & ~abort & ~l2_wb.ACK & ~l2_wb.RTY;
    assign done_rty = busy & ~abort & ~l2_wb.ACK & (l2_wb.RTY | wd_hit);

    assign l2_wb.ADR   = own_d ? dcache_wb.ADR   : icache_wb.ADR;
    assign l2_wb.DAT_M = own_d ? dcache_wb.DAT_M : icache_wb.DAT_M;
    assign l2_wb.SEL   = own_d ? dcache_wb.SEL   : icache_wb.SEL;
    assign l2_wb.WE    = busy & (own_d ? dcache_wb.WE : icache_wb.WE);
    assign l2_wb.CYC   = busy & own_cyc & ~fire;
    assign l2_wb.STB   = busy & own_cyc & own_stb & ~fire;

    assign icache_wb.DAT_S = l2_wb.DAT_S;
    assign dcache_wb.DAT_S = l2_wb.DAT_S;
    assign icache_wb.ACK   = own_i & done_ack;
    assign icache_wb.RTY   = own_i & done_rty;
    assign dcache_wb.ACK   = own_d & done_ack;
    assign dcache_wb.RTY   = own_d & done_rty;

    assign grant       = state;
    assign timeout_err = fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= ~FIRST_PRIORITY_D;
            wd_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= 8'd0;
                    if (req_i && req_d) begin
                        state <= last_d ? GRANT_I : GRANT_D;
                    end else if (req_i) begin
                        state <= GRANT_I;
                    end else if (req_d) begin
                        state <= GRANT_D;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (done_ack || done_rty) begin
                        state  <= IDLE;
                        last_d <= own_d;
                    end else if (wd_cnt != 8'hFF) begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_grant_legal: assert property (@(posedge clk) disable iff (rst) grant != 2'b11);
    a_single_ack:  assert property (@(posedge clk) disable iff (rst)
                                    !((icache_wb.ACK | icache_wb.RTY) && (dcache_wb.ACK | dcache_wb.RTY)));
    a_cyc_owned:   assert property (@(posedge clk) disable iff (rst) l2_wb.CYC |-> busy);
endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench: expected L2 transactions are queued as requests are raised and checked as the L2 sees them.
module tb_l2_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] grant;
    logic timeout_err;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_arbiter_if icache_wb ();
    l2_arbiter_if dcache_wb ();
    l2_arbiter_if l2_wb ();

    l2_arbiter #(.TIMEOUT_CYCLES(8), .FIRST_PRIORITY_D(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .icache_wb   (icache_wb),
        .dcache_wb   (dcache_wb),
        .l2_wb       (l2_wb),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic [1:0]  gnt;
        logic [11:0] adr;
        logic        we;
    } xact_t;

    xact_t exp_q[$];

    localparam logic [127:0] RD_DATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0BAD_F00D;
    localparam logic [127:0] WR_DATA = 128'hA5A5_5A5A_1111_2222_3333_4444_5555_6666;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_i(input logic cyc, input logic [11:0] adr, input logic we,
                           input logic [127:0] dat, input logic [15:0] sel);
        icache_wb.CYC = cyc; icache_wb.STB = cyc; icache_wb.ADR = adr;
        icache_wb.WE = we; icache_wb.DAT_M = dat; icache_wb.SEL = sel;
    endtask

    task automatic drive_d(input logic cyc, input logic [11:0] adr, input logic we,
                           input logic [127:0] dat, input logic [15:0] sel);
        dcache_wb.CYC = cyc; dcache_wb.STB = cyc; dcache_wb.ADR = adr;
        dcache_wb.WE = we; dcache_wb.DAT_M = dat; dcache_wb.SEL = sel;
    endtask

    task automatic push_exp(input logic [1:0] gnt, input logic [11:0] adr, input logic we);
        xact_t e;
        e.gnt = gnt; e.adr = adr; e.we = we;
        exp_q.push_back(e);
    endtask

    // Returns the number of negedges until the L2 sees CYC&STB, or -1 if it never does.
    task automatic wait_l2(output int n);
        n = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (l2_wb.CYC && l2_wb.STB) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic ack_release(input bit port_d);
        tick();
        l2_wb.ACK = 1'b1;
        l2_wb.DAT_S = RD_DATA;
        tick();
        l2_wb.ACK = 1'b0;
        l2_wb.DAT_S = '0;
        if (port_d) drive_d(1'b0, 12'h000, 1'b0, '0, 16'h0000);
        else        drive_i(1'b0, 12'h000, 1'b0, '0, 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++; $display("FAIL reset_grant: got %b expected 00", grant);
        end
        checks++;
        if ({l2_wb.CYC, l2_wb.STB, l2_wb.WE} !== 3'b000) begin
            failures++; $display("FAIL reset_l2_ctrl: cyc/stb/we=%b expected 000", {l2_wb.CYC, l2_wb.STB, l2_wb.WE});
        end
        checks++;
        if ({icache_wb.ACK, icache_wb.RTY, dcache_wb.ACK, dcache_wb.RTY} !== 4'b0000) begin
            failures++; $display("FAIL reset_term: i_ack/i_rty/d_ack/d_rty=%b expected 0000",
                                 {icache_wb.ACK, icache_wb.RTY, dcache_wb.ACK, dcache_wb.RTY});
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        int n;
        xact_t e;
        drive_i(1'b1, 12'h0C0, 1'b0, '0, 16'hFFFF);
        drive_d(1'b1, 12'h3A5, 1'b0, '0, 16'hFFFF);
        push_exp(2'b10, 12'h3A5, 1'b0);
        push_exp(2'b01, 12'h0C0, 1'b0);
        wait_l2(n);
        checks++;
        if (n !== 2) begin
            failures++; $display("FAIL sim_latency: l2 request seen at negedge %0d expected 2", n);
        end
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR, l2_wb.WE} !== {e.gnt, e.adr, e.we}) begin
            failures++; $display("FAIL sim_first: grant=%b adr=%h we=%b expected grant=%b adr=%h we=%b",
                                 grant, l2_wb.ADR, l2_wb.WE, e.gnt, e.adr, e.we);
        end
        tick();
        l2_wb.ACK = 1'b1;
        @(negedge clk);
        checks++;
        if ({dcache_wb.ACK, icache_wb.ACK} !== 2'b10) begin
            failures++; $display("FAIL sim_ack_route: d_ack/i_ack=%b expected 10", {dcache_wb.ACK, icache_wb.ACK});
        end
        tick();
        l2_wb.ACK = 1'b0;
        drive_d(1'b0, 12'h000, 1'b0, '0, 16'h0000);
        @(negedge clk);
        checks++;
        if ({grant, l2_wb.CYC} !== 3'b000) begin
            failures++; $display("FAIL sim_turnaround: grant=%b cyc=%b expected grant=00 cyc=0", grant, l2_wb.CYC);
        end
        wait_l2(n);
        checks++;
        if (n !== 1) begin
            failures++; $display("FAIL sim_second_latency: seen at negedge %0d expected 1", n);
        end
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR, l2_wb.WE} !== {e.gnt, e.adr, e.we}) begin
            failures++; $display("FAIL sim_second: grant=%b adr=%h we=%b expected grant=%b adr=%h we=%b",
                                 grant, l2_wb.ADR, l2_wb.WE, e.gnt, e.adr, e.we);
        end
        ack_release(1'b0);
    endtask

    task automatic test_lone_read();
        int n;
        xact_t e;
        drive_i(1'b1, 12'h010, 1'b0, '0, 16'hFFFF);
        push_exp(2'b01, 12'h010, 1'b0);
        wait_l2(n);
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR, l2_wb.WE} !== {e.gnt, e.adr, e.we} || n !== 2) begin
            failures++; $display("FAIL lone_grant: grant=%b adr=%h we=%b at %0d expected grant=%b adr=%h we=%b at 2",
                                 grant, l2_wb.ADR, l2_wb.WE, n, e.gnt, e.adr, e.we);
        end
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                tick();
                @(negedge clk);
            end
            checks++;
            if ({icache_wb.ACK, dcache_wb.ACK} !== 2'b00) begin
                failures++; $display("FAIL lone_wait_%0d: i_ack/d_ack=%b expected 00", k, {icache_wb.ACK, dcache_wb.ACK});
            end
        end
        tick();
        l2_wb.ACK = 1'b1;
        l2_wb.DAT_S = RD_DATA;
        @(negedge clk);
        checks++;
        if ({icache_wb.ACK, dcache_wb.ACK} !== 2'b10 || icache_wb.DAT_S !== RD_DATA || dcache_wb.DAT_S !== RD_DATA) begin
            failures++; $display("FAIL lone_ack: i_ack/d_ack=%b i_dat=%h d_dat=%h expected 10 with %h",
                                 {icache_wb.ACK, dcache_wb.ACK}, icache_wb.DAT_S, dcache_wb.DAT_S, RD_DATA);
        end
        tick();
        l2_wb.ACK = 1'b0;
        l2_wb.DAT_S = '0;
        drive_i(1'b0, 12'h000, 1'b0, '0, 16'h0000);
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++; $display("FAIL lone_release: grant=%b expected 00", grant);
        end
    endtask

    task automatic test_write_priority();
        int n;
        xact_t e;
        tick();
        drive_i(1'b1, 12'h044, 1'b0, '0, 16'hFFFF);
        drive_d(1'b1, 12'h2F0, 1'b1, WR_DATA, 16'hFFFF);
        push_exp(2'b10, 12'h2F0, 1'b1);
        push_exp(2'b01, 12'h044, 1'b0);
        wait_l2(n);
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR, l2_wb.WE} !== {e.gnt, e.adr, e.we} || n !== 2) begin
            failures++; $display("FAIL wr_grant: grant=%b adr=%h we=%b at %0d expected grant=%b adr=%h we=%b at 2",
                                 grant, l2_wb.ADR, l2_wb.WE, n, e.gnt, e.adr, e.we);
        end
        checks++;
        if (l2_wb.SEL !== 16'hFFFF || l2_wb.DAT_M !== WR_DATA) begin
            failures++; $display("FAIL wr_payload: sel=%h dat=%h expected sel=ffff dat=%h", l2_wb.SEL, l2_wb.DAT_M, WR_DATA);
        end
        tick();
        l2_wb.ACK = 1'b1;
        @(negedge clk);
        checks++;
        if ({dcache_wb.ACK, icache_wb.ACK, icache_wb.RTY} !== 3'b100) begin
            failures++; $display("FAIL wr_i_waits: d_ack/i_ack/i_rty=%b expected 100",
                                 {dcache_wb.ACK, icache_wb.ACK, icache_wb.RTY});
        end
        tick();
        l2_wb.ACK = 1'b0;
        drive_d(1'b0, 12'h000, 1'b0, '0, 16'h0000);
        wait_l2(n);
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR, l2_wb.WE} !== {e.gnt, e.adr, e.we} || n !== 2) begin
            failures++; $display("FAIL wr_then_i: grant=%b adr=%h we=%b at %0d expected grant=%b adr=%h we=%b at 2",
                                 grant, l2_wb.ADR, l2_wb.WE, n, e.gnt, e.adr, e.we);
        end
        ack_release(1'b0);
    endtask

    task automatic test_retry();
        int n;
        xact_t e;
        drive_i(1'b1, 12'h123, 1'b0, '0, 16'hFFFF);
        push_exp(2'b01, 12'h123, 1'b0);
        wait_l2(n);
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR} !== {e.gnt, e.adr} || n !== 2) begin
            failures++; $display("FAIL rty_grant: grant=%b adr=%h at %0d expected grant=%b adr=%h at 2",
                                 grant, l2_wb.ADR, n, e.gnt, e.adr);
        end
        tick();
        drive_d(1'b1, 12'h3C3, 1'b0, '0, 16'hFFFF);
        push_exp(2'b10, 12'h3C3, 1'b0);
        push_exp(2'b01, 12'h123, 1'b0);
        l2_wb.RTY = 1'b1;
        @(negedge clk);
        checks++;
        if ({icache_wb.RTY, icache_wb.ACK, dcache_wb.RTY, dcache_wb.ACK} !== 4'b1000) begin
            failures++; $display("FAIL rty_route: i_rty/i_ack/d_rty/d_ack=%b expected 1000",
                                 {icache_wb.RTY, icache_wb.ACK, dcache_wb.RTY, dcache_wb.ACK});
        end
        tick();
        l2_wb.RTY = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant, icache_wb.RTY} !== 3'b000) begin
            failures++; $display("FAIL rty_idle: grant=%b i_rty=%b expected 00 0", grant, icache_wb.RTY);
        end
        wait_l2(n);
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR} !== {e.gnt, e.adr} || n !== 1) begin
            failures++; $display("FAIL rty_d_next: grant=%b adr=%h at %0d expected grant=%b adr=%h at 1",
                                 grant, l2_wb.ADR, n, e.gnt, e.adr);
        end
        ack_release(1'b1);
        wait_l2(n);
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR} !== {e.gnt, e.adr} || n !== 2) begin
            failures++; $display("FAIL rty_i_again: grant=%b adr=%h at %0d expected grant=%b adr=%h at 2",
                                 grant, l2_wb.ADR, n, e.gnt, e.adr);
        end
        ack_release(1'b0);
    endtask

    task automatic test_timeout();
        int n;
        xact_t e;
        drive_i(1'b1, 12'h0FF, 1'b0, '0, 16'hFFFF);
        push_exp(2'b01, 12'h0FF, 1'b0);
        wait_l2(n);
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR} !== {e.gnt, e.adr} || n !== 2) begin
            failures++; $display("FAIL wd_grant: grant=%b adr=%h at %0d expected grant=%b adr=%h at 2",
                                 grant, l2_wb.ADR, n, e.gnt, e.adr);
        end
        for (int k = 0; k < 8; k++) begin
            logic [2:0] want;
            if (k != 0) begin
                tick();
                @(negedge clk);
            end
            want = (k == 7) ? 3'b110 : 3'b001;
            checks++;
            if ({timeout_err, icache_wb.RTY, l2_wb.CYC} !== want) begin
                failures++; $display("FAIL wd_cycle_%0d: timeout_err/i_rty/l2_cyc=%b expected %b",
                                     k, {timeout_err, icache_wb.RTY, l2_wb.CYC}, want);
            end
        end
        tick();
        drive_i(1'b0, 12'h000, 1'b0, '0, 16'h0000);
        @(negedge clk);
        checks++;
        if ({grant, timeout_err, l2_wb.CYC} !== 4'b0000) begin
            failures++; $display("FAIL wd_after: grant=%b timeout_err=%b cyc=%b expected 00 0 0",
                                 grant, timeout_err, l2_wb.CYC);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        xact_t e;
        tick();
        drive_d(1'b1, 12'h555, 1'b0, '0, 16'hFFFF);
        push_exp(2'b10, 12'h555, 1'b0);
        wait_l2(n);
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR} !== {e.gnt, e.adr} || n !== 2) begin
            failures++; $display("FAIL rstmid_grant: grant=%b adr=%h at %0d expected grant=%b adr=%h at 2",
                                 grant, l2_wb.ADR, n, e.gnt, e.adr);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_d(1'b0, 12'h000, 1'b0, '0, 16'h0000);
        @(negedge clk);
        checks++;
        if ({grant, l2_wb.CYC, icache_wb.ACK, icache_wb.RTY, dcache_wb.ACK, dcache_wb.RTY} !== 7'b0) begin
            failures++; $display("FAIL rstmid_abandon: grant=%b cyc=%b terms=%b expected 00 0 0000", grant, l2_wb.CYC,
                                 {icache_wb.ACK, icache_wb.RTY, dcache_wb.ACK, dcache_wb.RTY});
        end
        tick();
        drive_i(1'b1, 12'h0AA, 1'b0, '0, 16'hFFFF);
        drive_d(1'b1, 12'h3A5, 1'b0, '0, 16'hFFFF);
        push_exp(2'b10, 12'h3A5, 1'b0);
        push_exp(2'b01, 12'h0AA, 1'b0);
        wait_l2(n);
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR} !== {e.gnt, e.adr} || n !== 2) begin
            failures++; $display("FAIL rstmid_d_again: grant=%b adr=%h at %0d expected grant=%b adr=%h at 2",
                                 grant, l2_wb.ADR, n, e.gnt, e.adr);
        end
        ack_release(1'b1);
        wait_l2(n);
        e = exp_q.pop_front();
        checks++;
        if ({grant, l2_wb.ADR} !== {e.gnt, e.adr} || n !== 2) begin
            failures++; $display("FAIL rstmid_i_after: grant=%b adr=%h at %0d expected grant=%b adr=%h at 2",
                                 grant, l2_wb.ADR, n, e.gnt, e.adr);
        end
        ack_release(1'b0);
    endtask

    initial begin
        drive_i(1'b0, 12'h000, 1'b0, '0, 16'h0000);
        drive_d(1'b0, 12'h000, 1'b0, '0, 16'h0000);
        l2_wb.ACK = 1'b0;
        l2_wb.RTY = 1'b0;
        l2_wb.DAT_S = '0;
        test_reset();
        test_simultaneous();
        test_lone_read();
        test_write_priority();
        test_retry();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: %0d transactions left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "bench time limit reached");
    end
endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Two-master to one-slave wishbone arbiter that shares the single L2 cache port between the L1 instruction cache and the L1 data cache.
- Sits between the two L1 miss ports and the L2 cache's CPU-side slave interface.
- Sequences one 128-bit line transaction at a time and uses round-robin grant.
- Includes a watchdog that forces a retry if the L2 never terminates a cycle.

Parameters:
TIMEOUT_CYCLES, 255, cycles in a GRANT state with no ACK/RTY from L2 before a forced RTY; 0 disables the watchdog.
FIRST_PRIORITY_D, 1, when 1, last_grant resets to I so the D-cache wins the first simultaneous request.

Ports:
clk  input  1  system clock; all wishbone CLK members are ignored.
rst  input  1  synchronous active-high reset.
icache_wb  wishbone.slave  ADR 12 / DAT 128 / SEL 16  I-cache miss port.
dcache_wb  wishbone.slave  ADR 12 / DAT 128 / SEL 16  D-cache miss and writeback port.
l2_wb  wishbone.master  ADR 12 / DAT 128 / SEL 16  toward L2 cache CPU port.
grant  output  2  current owner: 00 none, 01 I, 10 D.
timeout_err  output  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Request definition: req_i = icache_wb.CYC & icache_wb.STB; req_d likewise for dcache_wb.
- Reset (rst sampled high at a clk edge):
  - state=IDLE, grant=00, timeout_err=0, watchdog count=0.
  - l2_wb.CYC/STB/WE=0.
  - All master-side ACK/RTY=0.
  - last_grant = I if FIRST_PRIORITY_D=1, else D.
  - Reset mid-transaction abandons the cycle immediately; L2 sees CYC drop on the next cycle.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - Nothing is forwarded to L2; CYC=STB=0, ADR/DAT_M/SEL/WE driven from the I port but don't-care.
  - Only req_i -> GRANT_I. Only req_d -> GRANT_D.
  - Both -> the port not equal to last_grant.
  - Arbitration costs exactly 1 cycle; L2 sees the request the cycle after req is first seen.
- GRANT_x:
  - l2_wb ADR, DAT_M, SEL, WE, CYC, STB are combinationally muxed from port x.
  - l2_wb.DAT_S is fanned out to both DAT_S outputs.
  - ACK and RTY are routed only to port x; the other port sees ACK=RTY=0.
- GRANT_x termination:
  - l2_wb.ACK=1 -> ACK to x same cycle, last_grant<=x, -> IDLE.
  - l2_wb.RTY=1 -> RTY to x same cycle, last_grant<=x, -> IDLE; the master re-requests and re-arbitrates.
  - ACK and RTY together -> treat as ACK.
  - Port x drops CYC (abort) -> l2_wb.CYC/STB deassert the same cycle, -> IDLE, last_grant unchanged.
- Turnaround: one mandatory IDLE cycle between transactions, so back-to-back ACKs never occur. A master holding STB after its ACK is re-arbitrated as a new request.
- Watchdog:
  - 8-bit counter, cleared on entering GRANT_x, incremented each GRANT cycle without ACK/RTY.
  - When count == TIMEOUT_CYCLES-1 and there is still no ACK/RTY: assert RTY to x, pulse timeout_err, deassert l2_wb.CYC, -> IDLE, last_grant<=x.
  - The counter saturates and never wraps.
- grant is registered and equals the encoding of the current state.
- The ACK the L2 returns is single-cycle and never registered or delayed by the arbiter.

Test Plan:
- Reset with FIRST_PRIORITY_D=1, then req_i and req_d both raised the same cycle -> grant=10 next cycle, l2_wb.ADR = dcache ADR (e.g. 12'h3A5). After L2 ACK, one IDLE cycle, then grant=01 and I is serviced.
- Lone I read ADR=12'h010, L2 ACKs 4 cycles after its STB with DAT_S=128'hDEAD_BEEF... -> icache ACK in the same cycle with that data, dcache ACK=0 throughout, grant returns to 00.
- D write (WE=1, SEL=16'hFFFF) while I is requesting -> the I request waits with no ACK/RTY. D completes, then I is granted. The L2 WE sample is 1 during D and 0 during I.
- L2 returns RTY to granted I -> icache RTY for one cycle, state IDLE. With D also requesting, D is granted next (last_grant=I).
- TIMEOUT_CYCLES=8 with L2 never responding -> 8 cycles after the grant: icache RTY=1, timeout_err pulses once, l2_wb.CYC=0, arbiter back in IDLE.
- Assert rst during GRANT_D with L2 silent -> next cycle grant=00, l2_wb.CYC=0, no ACK/RTY to either port. The subsequent simultaneous request goes to D again.
